// File: rtl/door_interlock_ctrl.sv
// rtl/door_interlock_ctrl.sv - multi-door open/close controller with airlock interlock
// Each door runs a Moore FSM; only one door may leave CLOSED at a time, granted round-robin.
module door_interlock_ctrl #(
  parameter int N_DOORS    = 2,
  parameter int TIMER_W    = 8,
  parameter int TIMEOUT    = 200,
  parameter int AUTO_CLOSE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DOORS-1:0] open_req,
  input  logic [N_DOORS-1:0] close_req,
  input  logic [N_DOORS-1:0] is_open,
  input  logic [N_DOORS-1:0] is_closed,
  input  logic [N_DOORS-1:0] fault_clr,
  output logic [N_DOORS-1:0] open_cmd,
  output logic [N_DOORS-1:0] close_cmd,
  output logic [N_DOORS-1:0] fault,
  output logic               busy
);

  localparam logic [2:0] S_CLOSED  = 3'd0;
  localparam logic [2:0] S_OPENING = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_CLOSING = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam int PTR_W = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;

  // Timer values at which the current cycle is the last one allowed in the state.
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] AC_LAST = (AUTO_CLOSE == 0) ? '0 : TIMER_W'(AUTO_CLOSE - 1);
  localparam logic               AC_EN   = (AUTO_CLOSE != 0);

  logic [2:0]         r_state [N_DOORS];
  logic [TIMER_W-1:0] r_timer [N_DOORS];
  logic [PTR_W-1:0]   r_ptr;

  logic [2:0]         w_next [N_DOORS];
  logic [N_DOORS-1:0] w_closed;
  logic [N_DOORS-1:0] w_grant;
  logic               w_all_closed;
  logic               w_req_any;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;

  always_comb begin
    w_closed = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      w_closed[i] = (r_state[i] == S_CLOSED);
    end
    w_all_closed = &w_closed;
  end

  // Scan from the far end toward the pointer so the nearest requester wins last.
  always_comb begin
    w_req_any = 1'b0;
    w_winner  = '0;
    w_idx     = '0;
    for (int k = N_DOORS - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N_DOORS);
      if (open_req[w_idx]) begin
        w_req_any = 1'b1;
        w_winner  = w_idx;
      end
    end
    w_grant = '0;
    if (w_all_closed && w_req_any) begin
      w_grant[w_winner] = 1'b1;
    end
    w_ptr_nxt = PTR_W'((int'(w_winner) + 1) % N_DOORS);
  end

  // Within each state the checks are ordered sensor > close_req > timer.
  always_comb begin
    for (int i = 0; i < N_DOORS; i++) begin
      w_next[i] = r_state[i];
      case (r_state[i])
        S_CLOSED: begin
          if (w_grant[i]) w_next[i] = S_OPENING;
        end
        S_OPENING: begin
          if (is_open[i] && !is_closed[i]) w_next[i] = S_OPEN;
          else if (close_req[i])           w_next[i] = S_CLOSING;
          else if (r_timer[i] == TO_LAST)  w_next[i] = S_FAULT;
        end
        S_OPEN: begin
          if (close_req[i])                          w_next[i] = S_CLOSING;
          else if (AC_EN && (r_timer[i] == AC_LAST)) w_next[i] = S_CLOSING;
        end
        S_CLOSING: begin
          if (is_closed[i] && !is_open[i]) w_next[i] = S_CLOSED;
          else if (r_timer[i] == TO_LAST)  w_next[i] = S_FAULT;
        end
        S_FAULT: begin
          if (fault_clr[i]) w_next[i] = S_CLOSING;
        end
        default: w_next[i] = S_CLOSED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DOORS; i++) begin
        r_state[i] <= S_CLOSED;
        r_timer[i] <= '0;
      end
      r_ptr <= '0;
    end else begin
      for (int i = 0; i < N_DOORS; i++) begin
        r_state[i] <= w_next[i];
        if (w_next[i] != r_state[i]) begin
          r_timer[i] <= '0;
        end else if (r_timer[i] != '1) begin
          r_timer[i] <= r_timer[i] + 1'b1;
        end
      end
      if (|w_grant) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  always_comb begin
    open_cmd  = '0;
    close_cmd = '0;
    fault     = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      open_cmd[i]  = (r_state[i] == S_OPENING);
      close_cmd[i] = (r_state[i] == S_CLOSING);
      fault[i]     = (r_state[i] == S_FAULT);
    end
    busy = ~w_all_closed;
  end

endmodule

// File: tb/tb_door_interlock_ctrl.sv
// tb/tb_door_interlock_ctrl.sv - directed scoreboard bench for door_interlock_ctrl
// Two instances share stimulus: u_dut_a without auto-close, u_dut_b with AUTO_CLOSE=16.
module tb_door_interlock_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] open_req, close_req, is_open, is_closed, fault_clr;
  logic [1:0] a_open, a_close, a_fault;
  logic       a_busy;
  logic [1:0] b_open, b_close, b_fault;
  logic       b_busy;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_pass;

  door_interlock_ctrl #(.N_DOORS(2), .TIMER_W(8), .TIMEOUT(8), .AUTO_CLOSE(0)) u_dut_a (
    .clk(clk), .reset(reset), .open_req(open_req), .close_req(close_req),
    .is_open(is_open), .is_closed(is_closed), .fault_clr(fault_clr),
    .open_cmd(a_open), .close_cmd(a_close), .fault(a_fault), .busy(a_busy)
  );

  door_interlock_ctrl #(.N_DOORS(2), .TIMER_W(8), .TIMEOUT(8), .AUTO_CLOSE(16)) u_dut_b (
    .clk(clk), .reset(reset), .open_req(open_req), .close_req(close_req),
    .is_open(is_open), .is_closed(is_closed), .fault_clr(fault_clr),
    .open_cmd(b_open), .close_cmd(b_close), .fault(b_fault), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {open_cmd, close_cmd, fault, busy}.
  function automatic logic [6:0] mk(input logic [1:0] o, input logic [1:0] c,
                                    input logic [1:0] f, input logic b);
    return {o, c, f, b};
  endfunction

  task automatic chk(input string tag);
    exp_t e;
    logic [6:0] oa, ob;
    e  = q.pop_front();
    oa = {a_open, a_close, a_fault, a_busy};
    ob = {b_open, b_close, b_fault, b_busy};
    n_chk++;
    assert (oa === e.a) n_pass++;
    else $error("FAIL %s dut_a observed=%b expected=%b", tag, oa, e.a);
    n_chk++;
    assert (ob === e.b) n_pass++;
    else $error("FAIL %s dut_b observed=%b expected=%b", tag, ob, e.b);
  endtask

  task automatic tick2(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    q.push_back('{a: ea, b: eb});
    @(posedge clk);
    @(negedge clk);
    chk(tag);
  endtask

  task automatic tick(input string tag, input logic [6:0] e);
    tick2(tag, e, e);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; open_req = '0; close_req = '0; is_open = '0; is_closed = 2'b11; fault_clr = '0;

    // reset state
    @(negedge clk);
    tick("reset_state", mk(0, 0, 0, 0));
    reset = 1'b1;
    tick("idle", mk(0, 0, 0, 0));

    // 1: basic open/close of door0
    open_req = 2'b01;
    tick("t1_open0", mk(2'b01, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b10;
    tick("t1_open1", mk(2'b01, 0, 0, 1));
    tick("t1_open2", mk(2'b01, 0, 0, 1));
    is_open = 2'b01;
    tick("t1_opened", mk(0, 0, 0, 1));
    close_req = 2'b01;
    tick("t1_closing", mk(0, 2'b01, 0, 1));
    close_req = 2'b00; is_open = 2'b00;
    tick("t1_closing_hold", mk(0, 2'b01, 0, 1));
    is_closed = 2'b11;
    tick("t1_closed", mk(0, 0, 0, 0));

    // 2: simultaneous requests from a fresh reset
    reset = 1'b0;
    tick("t2_reset", mk(0, 0, 0, 0));
    reset = 1'b1;
    open_req = 2'b11;
    tick("t2_grant0", mk(2'b01, 0, 0, 1));
    tick("t2_door1_blocked", mk(2'b01, 0, 0, 1));
    is_closed = 2'b10; is_open = 2'b01;
    tick("t2_open0", mk(0, 0, 0, 1));
    close_req = 2'b01;
    tick("t2_closing0", mk(0, 2'b01, 0, 1));
    close_req = 2'b00; is_open = 2'b00; is_closed = 2'b11;
    tick("t2_closed0", mk(0, 0, 0, 0));
    tick("t2_grant1", mk(2'b10, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b01; is_open = 2'b10;
    tick("t2_open1", mk(0, 0, 0, 1));
    close_req = 2'b10;
    tick("t2_closing1", mk(0, 2'b10, 0, 1));
    close_req = 2'b00; is_open = 2'b00; is_closed = 2'b11;
    tick("t2_closed1", mk(0, 0, 0, 0));

    // 3: door1 held off while door0 is out
    open_req = 2'b01;
    tick("t3_grant0", mk(2'b01, 0, 0, 1));
    open_req = 2'b10; is_open = 2'b01; is_closed = 2'b10;
    tick("t3_open0", mk(0, 0, 0, 1));
    tick("t3_block_a", mk(0, 0, 0, 1));
    tick("t3_block_b", mk(0, 0, 0, 1));
    close_req = 2'b01;
    tick("t3_closing0", mk(0, 2'b01, 0, 1));
    close_req = 2'b00; is_open = 2'b00; is_closed = 2'b11;
    tick("t3_closed0", mk(0, 0, 0, 0));
    tick("t3_grant1", mk(2'b10, 0, 0, 1));
    open_req = 2'b00; close_req = 2'b10;
    tick("t3_abort1", mk(0, 2'b10, 0, 1));
    close_req = 2'b00;
    tick("t3_closed1", mk(0, 0, 0, 0));

    // 4: opening timeout, fault, clear
    open_req = 2'b01;
    tick("t4_grant0", mk(2'b01, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b10;
    for (int i = 0; i < 7; i++) tick("t4_opening", mk(2'b01, 0, 0, 1));
    tick("t4_fault", mk(0, 0, 2'b01, 1));
    open_req = 2'b10;
    tick("t4_fault_blocks", mk(0, 0, 2'b01, 1));
    open_req = 2'b00; fault_clr = 2'b01;
    tick("t4_clear", mk(0, 2'b01, 0, 1));
    fault_clr = 2'b00; is_closed = 2'b11;
    tick("t4_closed", mk(0, 0, 0, 0));

    // 5a: auto-close exactly 16 cycles after entering OPEN (dut_b only)
    open_req = 2'b01;
    tick("t5_grant0", mk(2'b01, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b10; is_open = 2'b01;
    tick("t5_open", mk(0, 0, 0, 1));
    for (int i = 0; i < 15; i++) tick("t5_hold_open", mk(0, 0, 0, 1));
    tick2("t5_autoclose", mk(0, 0, 0, 1), mk(0, 2'b01, 0, 1));
    close_req = 2'b01;
    tick("t5_closing", mk(0, 2'b01, 0, 1));
    close_req = 2'b00; is_open = 2'b00; is_closed = 2'b11;
    tick("t5_closed", mk(0, 0, 0, 0));

    // 5b: sensor wins over timeout on the same edge
    open_req = 2'b01;
    tick("t5b_grant0", mk(2'b01, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b10;
    for (int i = 0; i < 7; i++) tick("t5b_opening", mk(2'b01, 0, 0, 1));
    is_open = 2'b01;
    tick("t5b_open_not_fault", mk(0, 0, 0, 1));
    close_req = 2'b01;
    tick("t5b_closing", mk(0, 2'b01, 0, 1));
    close_req = 2'b00; is_open = 2'b00; is_closed = 2'b11;
    tick("t5b_closed", mk(0, 0, 0, 0));

    // 6: asynchronous reset mid-OPENING
    open_req = 2'b01;
    tick("t6_grant0", mk(2'b01, 0, 0, 1));
    open_req = 2'b00; is_closed = 2'b10;
    #2 reset = 1'b0;
    #1;
    q.push_back('{a: mk(0, 0, 0, 0), b: mk(0, 0, 0, 0)});
    chk("t6_async_drop");
    @(negedge clk);
    reset = 1'b1;
    tick("t6_no_reopen_a", mk(0, 0, 0, 0));
    tick("t6_no_reopen_b", mk(0, 0, 0, 0));
    open_req = 2'b01;
    tick("t6_reopen", mk(2'b01, 0, 0, 1));
    open_req = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
